mux8_scan_sequencer: RTL and testbench



---
 rtl/mux8_scan_sequencer_pkg.sv | 19 +
 rtl/mux8_scan_sequencer_if.sv | 28 ++
 rtl/mux8_scan_sequencer_slot_timer.sv | 30 +++
 rtl/mux8_scan_sequencer.sv | 125 ++++++++++++
 tb/tb_mux8_scan_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux8_scan_sequencer_pkg.sv
// Shared types and constants for the mux8x1 scan sequencer.
// No logic here: state encoding, widths and the select-step helper.
package mux_seq_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] LAST_IDX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel, input bit msb_first);
        return msb_first ? (sel - 3'd1) : (sel + 3'd1);
    endfunction

endpackage

// File: rtl/mux8_scan_sequencer_if.sv
// Bundle of the word handshake, mux drive/feedback and scan result signals.
// slave is the sequencer side; master is whatever feeds words and closes the mux loop.
interface mux8_scan_sequencer_if;
    import mux_seq_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mux_in;
    logic [SEL_W-1:0]  mux_sel;
    logic              mux_out;
    logic              ser_bit;
    logic              ser_valid;
    logic [DATA_W-1:0] cap_word;
    logic              done;
    logic              busy;

    modport slave (
        input  in_data, in_valid, mux_out,
        output in_ready, mux_in, mux_sel, ser_bit, ser_valid, cap_word, done, busy
    );

    modport master (
        output in_data, in_valid, mux_out,
        input  in_ready, mux_in, mux_sel, ser_bit, ser_valid, cap_word, done, busy
    );

endinterface

// File: rtl/mux8_scan_sequencer_slot_timer.sv
// Slot timer: counts cycles within a select slot, tick on the last cycle (slot_cnt == DIV-1).
// Latency: tick is combinational from the counter; the counter wraps to 0 on tick.
// Backpressure: none; clear wins over run.
module slot_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST_CNT = 8'(DIV - 1);

    logic [7:0] slot_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= 8'd0;
        end else if (clear) begin
            slot_cnt <= 8'd0;
        end else if (run) begin
            slot_cnt <= tick ? 8'd0 : (slot_cnt + 8'd1);
        end
    end

    assign tick = (slot_cnt == LAST_CNT);

endmodule

// File: rtl/mux8_scan_sequencer.sv
// Scans an accepted byte through mux8x1, one select slot per DIV cycles, rebuilding it from mux_out.
// Latency: 8 samples at E0+k*DIV, done with the 8th ser_valid, in_ready back after E0+8*DIV+1.
// Backpressure: in_ready only in IDLE; in_valid outside IDLE is ignored, nothing is queued.
module mux8_scan_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux8_scan_sequencer_if.slave  bus
);

    localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? 3'd7 : 3'd0;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mux_in_q, mux_in_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              ser_bit_q, ser_bit_d;
    logic              ser_valid_q, ser_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic accept, tick, sample, last_sample;

    assign accept      = (state_q == IDLE) && bus.in_valid;
    assign sample      = (state_q == SCAN) && tick;
    assign last_sample = sample && (bit_cnt_q == LAST_IDX);

    slot_timer #(.DIV(DIV)) u_slot_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .run   (state_q == SCAN),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (last_sample) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mux_in_d    = mux_in_q;
        sel_d       = sel_q;
        bit_cnt_d   = bit_cnt_q;
        shadow_d    = shadow_q;
        cap_d       = cap_q;
        ser_bit_d   = ser_bit_q;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        if (accept) begin
            mux_in_d  = bus.in_data;
            sel_d     = FIRST_SEL;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
        end
        if (sample) begin
            ser_bit_d         = bus.mux_out;
            ser_valid_d       = 1'b1;
            shadow_d[sel_q]   = bus.mux_out;
            if (bit_cnt_q == LAST_IDX) begin
                // Final bit merged straight into cap_word; select stays on the last position.
                cap_d  = shadow_d;
                done_d = 1'b1;
                busy_d = 1'b0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                sel_d     = step_sel(sel_q, MSB_FIRST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_in_q    <= '0;
            sel_q       <= '0;
            bit_cnt_q   <= '0;
            shadow_q    <= '0;
            cap_q       <= '0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mux_in_q    <= mux_in_d;
            sel_q       <= sel_d;
            bit_cnt_q   <= bit_cnt_d;
            shadow_q    <= shadow_d;
            cap_q       <= cap_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.mux_in    = mux_in_q;
    assign bus.mux_sel   = sel_q;
    assign bus.ser_bit   = ser_bit_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.cap_word  = cap_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux8_scan_sequencer.sv
// Bench: three sequencers (DIV4 LSB-first, DIV4 MSB-first, DIV1) each looped through an ideal mux8x1.
module tb_mux8_scan_sequencer;

    logic clk;
    logic rst_n;
    logic [7:0] tb_data [3];
    logic       tb_valid [3];
    int cur;
    int checks;
    int failures;

    mux8_scan_sequencer_if ifa ();
    mux8_scan_sequencer_if ifb ();
    mux8_scan_sequencer_if ifc ();

    mux8_scan_sequencer #(.DIV(4), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    mux8_scan_sequencer #(.DIV(4), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    mux8_scan_sequencer #(.DIV(1), .MSB_FIRST(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    assign ifa.mux_out  = ifa.mux_in[ifa.mux_sel];
    assign ifb.mux_out  = ifb.mux_in[ifb.mux_sel];
    assign ifc.mux_out  = ifc.mux_in[ifc.mux_sel];
    assign ifa.in_data  = tb_data[0];
    assign ifb.in_data  = tb_data[1];
    assign ifc.in_data  = tb_data[2];
    assign ifa.in_valid = tb_valid[0];
    assign ifb.in_valid = tb_valid[1];
    assign ifc.in_valid = tb_valid[2];

    logic       o_ready, o_bit, o_sv, o_done, o_busy;
    logic [7:0] o_mux_in, o_cap;
    logic [2:0] o_sel;

    always_comb begin
        o_ready = ifa.in_ready; o_bit = ifa.ser_bit; o_sv = ifa.ser_valid; o_done = ifa.done;
        o_busy = ifa.busy; o_mux_in = ifa.mux_in; o_cap = ifa.cap_word; o_sel = ifa.mux_sel;
        if (cur == 1) begin
            o_ready = ifb.in_ready; o_bit = ifb.ser_bit; o_sv = ifb.ser_valid; o_done = ifb.done;
            o_busy = ifb.busy; o_mux_in = ifb.mux_in; o_cap = ifb.cap_word; o_sel = ifb.mux_sel;
        end else if (cur == 2) begin
            o_ready = ifc.in_ready; o_bit = ifc.ser_bit; o_sv = ifc.ser_valid; o_done = ifc.done;
            o_busy = ifc.busy; o_mux_in = ifc.mux_in; o_cap = ifc.cap_word; o_sel = ifc.mux_sel;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [7:0] exp_ser;   // bit i = i-th serial bit in time order
        logic [7:0] exp_cap;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Select value visible after the n-th sample edge (it has already stepped, except after the last).
    function automatic logic [2:0] exp_sel(input int inst, input int n);
        if (inst == 1) return (n < 7) ? 3'(6 - n) : 3'd0;
        return (n < 7) ? 3'(n + 1) : 3'd7;
    endfunction

    task automatic do_word(input int inst, input logic [7:0] d, input logic [7:0] exp_ser, input logic [7:0] exp_cap);
        int div, n, done_c, waited;
        logic [7:0] bits;
        bit t_ok, s_ok;
        div = (inst == 2) ? 1 : 4;
        cur = inst;
        waited = 0;
        @(negedge clk);
        while (!o_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        tb_data[inst]  = d;
        tb_valid[inst] = 1'b1;
        @(negedge clk);
        tb_valid[inst] = 1'b0;
        chk("mux_in_latched", 32'(o_mux_in), 32'(d));
        chk("busy_set", 32'(o_busy), 32'd1);
        n = 0; done_c = -1; bits = 8'h00; t_ok = 1'b1; s_ok = 1'b1;
        for (int c = 1; c <= 8 * div + 4 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (o_sv) begin
                if (n < 8) bits[n] = o_bit;
                if (c != (n + 1) * div) t_ok = 1'b0;
                if (o_sel != exp_sel(inst, n)) s_ok = 1'b0;
                n++;
            end
            if (o_done) done_c = c;
        end
        chk("ser_valid_count", 32'(n), 32'd8);
        chk("ser_bit_sequence", 32'(bits), 32'(exp_ser));
        chk("ser_valid_timing_ok", 32'(t_ok), 32'd1);
        chk("mux_sel_stepping_ok", 32'(s_ok), 32'd1);
        chk("done_cycle", 32'(done_c), 32'(8 * div));
        chk("cap_word", 32'(o_cap), 32'(exp_cap));
        chk("busy_clear_at_done", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_done", 32'(o_ready), 32'd1);
        chk("done_one_cycle", 32'(o_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cap1, cap2;
        logic [31:0] sv_mask;
        int d1, d2, n, done_c;
        bit held_ok, quiet_ok;

        tbl[0] = '{0, 8'hAA, 8'hAA, 8'hAA};
        tbl[1] = '{0, 8'h3C, 8'h3C, 8'h3C};
        tbl[2] = '{1, 8'hC3, 8'hC3, 8'hC3};
        tbl[3] = '{1, 8'h01, 8'h80, 8'h01};
        tbl[4] = '{1, 8'hB4, 8'h2D, 8'hB4};
        tbl[5] = '{2, 8'hFF, 8'hFF, 8'hFF};
        tbl[6] = '{2, 8'h01, 8'h01, 8'h01};

        checks = 0; failures = 0; cur = 0;
        for (int i = 0; i < 3; i++) begin
            tb_data[i] = 8'h00;
            tb_valid[i] = 1'b0;
        end
        rst_n = 1'b0;
        #3;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cap", 32'(o_cap), 32'd0);
        chk("rst_sel", 32'(o_sel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release_ready", 32'(o_ready), 32'd1);
        chk("idle_after_release_busy", 32'(o_busy), 32'd0);

        for (int i = 0; i < 7; i++)
            do_word(tbl[i].inst, tbl[i].data, tbl[i].exp_ser, tbl[i].exp_cap);

        // in_valid held through a scan, in_data changed mid-scan
        cur = 0;
        @(negedge clk);
        tb_data[0] = 8'hAA; tb_valid[0] = 1'b1;
        @(negedge clk);
        tb_data[0] = 8'h5A;
        held_ok = 1'b1; done_c = -1;
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (o_mux_in != 8'hAA) held_ok = 1'b0;
            if (o_done) done_c = c;
        end
        chk("hold_mux_in_stable", 32'(held_ok), 32'd1);
        chk("hold_first_done_cycle", 32'(done_c), 32'd32);
        chk("hold_first_cap", 32'(o_cap), 32'hAA);
        @(posedge clk); #1;
        chk("hold_ready_back", 32'(o_ready), 32'd1);
        chk("hold_not_yet_accepted", 32'(o_mux_in), 32'hAA);
        @(posedge clk); #1;
        chk("hold_second_accepted", 32'(o_mux_in), 32'h5A);
        chk("hold_second_busy", 32'(o_busy), 32'd1);
        tb_valid[0] = 1'b0;
        done_c = -1;
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (o_done) done_c = c;
        end
        chk("hold_second_done_cycle", 32'(done_c), 32'd32);
        chk("hold_second_cap", 32'(o_cap), 32'h5A);
        @(posedge clk); #1;

        // DIV=1 back-to-back, valid held
        cur = 2;
        @(negedge clk);
        tb_data[2] = 8'hFF; tb_valid[2] = 1'b1;
        @(negedge clk);
        tb_data[2] = 8'h01;
        sv_mask = 32'h0; d1 = -1; d2 = -1; cap1 = 8'h00; cap2 = 8'h00;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (o_sv) sv_mask[c] = 1'b1;
            if (o_done) begin
                if (d1 < 0) begin d1 = c; cap1 = o_cap; end
                else if (d2 < 0) begin d2 = c; cap2 = o_cap; end
            end
            if (d1 > 0 && c == d1 + 2) tb_valid[2] = 1'b0;
        end
        chk("div1_ser_valid_pattern", sv_mask, 32'h0007F9FE);
        chk("div1_first_done", 32'(d1), 32'd8);
        chk("div1_second_done", 32'(d2), 32'd18);
        chk("div1_first_cap", 32'(cap1), 32'hFF);
        chk("div1_second_cap", 32'(cap2), 32'h01);

        // reset after the 3rd ser_valid of a scan
        cur = 0;
        @(negedge clk);
        tb_data[0] = 8'hE7; tb_valid[0] = 1'b1;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        n = 0;
        for (int c = 1; c <= 40 && n < 3; c++) begin
            @(posedge clk); #1;
            if (o_sv) n++;
        end
        chk("midscan_third_ser_valid", 32'(n), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mux_in", 32'(o_mux_in), 32'd0);
        chk("midrst_sel", 32'(o_sel), 32'd0);
        chk("midrst_ser_bit", 32'(o_bit), 32'd0);
        chk("midrst_ser_valid", 32'(o_sv), 32'd0);
        chk("midrst_cap", 32'(o_cap), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (o_done || o_sv || o_busy || o_cap != 8'h00) quiet_ok = 1'b0;
        end
        chk("post_reset_quiet", 32'(quiet_ok), 32'd1);
        do_word(0, 8'h96, 8'h96, 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
